// File: rtl/memory_pkg.sv
// Shared definitions for the memory read-side sequencer: address width
// helper, command layout and FSM state encoding.
package memory_pkg;

  // Address width for a given memory depth (at least one bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Default memory geometry used by the command struct below.
  localparam int MEM_D = 256;
  localparam int MEM_A = addr_width(MEM_D);

  // Command word as presented on cmd_data: {count_m1, base}.
  typedef struct packed {
    logic [MEM_A-1:0] count_m1;
    logic [MEM_A-1:0] base;
  } memory_cmd_t;

  // Reader sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

endpackage

// File: rtl/memory_reader_buffer.sv
// N-deep, W-wide synchronous FIFO used as the return buffer of the reader.
// The head word is held in flops, so a pushed word becomes visible on the
// output one cycle after the push.
module buffer #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(N);

  logic [W-1:0]  r_mem [N];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_entry
      // Each entry captures the incoming word when the write pointer selects it
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_mem[gi] <= '0;
        end else if (w_push && (r_wr_ptr == PW'(gi))) begin
          r_mem[gi] <= in_data;
        end
      end
    end
  endgenerate

  // Pointers wrap naturally because N is a power of two; count tracks occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/memory_reader.sv
// Read-side sequencer in front of the memory ar/r channels. Accepts a
// {count_m1, base} command, issues sequential addresses (wrapping modulo D),
// buffers returned words and streams them out with a last marker. A credit
// counter bounds reads in flight to the buffer depth so output back-pressure
// never stalls the memory return channel.
module memory_reader
  import memory_pkg::*;
#(
  parameter int W = 16,
  parameter int D = 256,
  parameter int N = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2*addr_width(D)-1:0]    cmd_data,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  output logic [addr_width(D)-1:0]      ar_data,
  output logic                          ar_valid,
  input  logic                          ar_ready,
  input  logic [W-1:0]                  r_data,
  input  logic                          r_valid,
  output logic                          r_ready,
  output logic [W-1:0]                  out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last
);

  localparam int A  = addr_width(D);
  localparam int LW = A + 1;               // holds lengths up to D
  localparam int CW = $clog2(N + 1);       // holds credits up to N
  localparam logic [A-1:0]  ADDR_MAX = A'(D - 1);
  localparam logic [CW-1:0] N_CNT    = CW'(N);
  localparam logic [LW-1:0] ONE_LEN  = LW'(1);

  reader_state_t r_state;
  logic [A-1:0]  r_addr;
  logic [LW-1:0] r_issue_left;
  logic [LW-1:0] r_recv_left;
  logic [LW-1:0] r_popped;
  logic [A-1:0]  r_len_m1;
  logic [CW-1:0] r_credits;

  logic [A-1:0]  w_cmd_count_m1;
  logic [A-1:0]  w_cmd_base;
  logic [LW-1:0] w_cmd_len;
  logic          w_cmd_fire;
  logic          w_ar_fire;
  logic          w_r_fire;
  logic          w_out_fire;
  logic          w_buf_empty;

  assign w_cmd_count_m1 = cmd_data[2*A-1:A];
  assign w_cmd_base     = cmd_data[A-1:0];
  assign w_cmd_len      = {1'b0, w_cmd_count_m1} + 1'b1;

  // Channel controls depend only on registered state, never on the same
  // channel's ready, so valids stay stable until their transfer.
  assign cmd_ready = (r_state == IDLE);
  assign ar_valid  = (r_state == ISSUE) && (r_credits != N_CNT);
  assign ar_data   = r_addr;

  assign w_cmd_fire  = cmd_valid && cmd_ready;
  assign w_ar_fire   = ar_valid && ar_ready;
  assign w_r_fire    = r_valid && r_ready;
  assign w_out_fire  = out_valid && out_ready;
  assign w_buf_empty = !out_valid;

  // The head word is the last one of the command once length-1 words are gone
  assign out_last = out_valid && (r_popped == {1'b0, r_len_m1});

  // Command sequencing: latch the command, step addresses, wait for the drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_len_m1     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmd_fire) begin
            r_addr       <= w_cmd_base;
            r_issue_left <= w_cmd_len;
            r_len_m1     <= w_cmd_count_m1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_ar_fire) begin
            r_addr       <= (r_addr == ADDR_MAX) ? '0 : r_addr + 1'b1;
            r_issue_left <= r_issue_left - 1'b1;
            if (r_issue_left == ONE_LEN) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if ((r_recv_left == '0) && w_buf_empty) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Count of beats still expected back from memory for the current command
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_recv_left <= '0;
    end else if (w_cmd_fire) begin
      r_recv_left <= w_cmd_len;
    end else if (w_r_fire && (r_recv_left != '0)) begin
      r_recv_left <= r_recv_left - 1'b1;
    end
  end

  // Count of words already streamed out, used to flag the final word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_popped <= '0;
    end else if (w_cmd_fire) begin
      r_popped <= '0;
    end else if (w_out_fire) begin
      r_popped <= r_popped + 1'b1;
    end
  end

  // Credits: reads issued but not yet popped; capped at N by gating ar_valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_credits <= '0;
    end else begin
      case ({w_ar_fire, w_out_fire})
        2'b10:   r_credits <= r_credits + 1'b1;
        2'b01:   r_credits <= r_credits - 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  buffer #(
    .W (W),
    .N (N)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .in_data   (r_data),
    .in_valid  (r_valid),
    .in_ready  (r_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule
